// File: rtl/rv_core_pkg.sv
// Shared core definitions: the canonical nop encoding, the default boot address
// and the fetch-stage state encoding.
package rv_core_pkg;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} fetch_state_t;
endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, talks to instruction memory over req/ack,
// and keeps one fetched instruction (plus one pending word) ready for IF/ID.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = rv_core_pkg::RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = rv_core_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_out,
    output logic [31:0] PC_4_out,
    output logic [31:0] instr_out,
    output logic        nop_out
);
    import rv_core_pkg::*;

    fetch_state_t state, state_n;
    logic [31:0]  pc_q, pc_n;
    logic         req_n;
    logic [31:0]  addr_n;
    logic [31:0]  pend_pc, pend_instr;

    logic consume, buf_free;
    logic buf_clear, buf_load_mem, buf_load_pend, pend_load;

    assign consume  = !nop_out && !stall;
    assign buf_free = nop_out || consume;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Redirect overrides everything; otherwise ack/stall decide where the word lands.
    always_comb begin
        state_n       = state;
        pc_n          = pc_q;
        req_n         = imem_req;
        addr_n        = imem_addr;
        buf_clear     = consume;
        buf_load_mem  = 1'b0;
        buf_load_pend = 1'b0;
        pend_load     = 1'b0;
        if (redirect) begin
            buf_clear = 1'b1;
            pc_n      = redirect_pc;
            case (state)
                REQ: begin
                    if (imem_ack) begin
                        req_n  = 1'b1;
                        addr_n = redirect_pc;
                    end else begin
                        state_n = DROP;
                    end
                end
                DROP: ;
                default: begin
                    state_n = REQ;
                    req_n   = 1'b1;
                    addr_n  = redirect_pc;
                end
            endcase
        end else begin
            case (state)
                IDLE: begin
                    state_n = REQ;
                    req_n   = 1'b1;
                    addr_n  = pc_q;
                end
                REQ: begin
                    if (imem_ack && buf_free) begin
                        buf_load_mem = 1'b1;
                        pc_n         = pc_q + 32'd4;
                        addr_n       = imem_addr + 32'd4;
                    end else if (imem_ack) begin
                        // Buffer full and stalled: park the word so the bus is released.
                        pend_load = 1'b1;
                        pc_n      = pc_q + 32'd4;
                        req_n     = 1'b0;
                        state_n   = HOLD;
                    end
                end
                HOLD: begin
                    if (consume) begin
                        buf_load_pend = 1'b1;
                        state_n       = REQ;
                        req_n         = 1'b1;
                        addr_n        = pc_q;
                    end
                end
                DROP: begin
                    if (imem_ack) begin
                        state_n = REQ;
                        addr_n  = pc_q;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            imem_req   <= 1'b0;
            imem_addr  <= 32'd0;
            pend_pc    <= 32'd0;
            pend_instr <= 32'd0;
            PC_out     <= 32'd0;
            PC_4_out   <= 32'd0;
            instr_out  <= NOP_INSTR;
            nop_out    <= 1'b1;
        end else begin
            pc_q      <= pc_n;
            imem_req  <= req_n;
            imem_addr <= addr_n;
            if (pend_load) begin
                pend_pc    <= imem_addr;
                pend_instr <= imem_rdata;
            end
            if (buf_load_mem) begin
                PC_out    <= imem_addr;
                PC_4_out  <= imem_addr + 32'd4;
                instr_out <= imem_rdata;
                nop_out   <= 1'b0;
            end else if (buf_load_pend) begin
                PC_out    <= pend_pc;
                PC_4_out  <= pend_pc + 32'd4;
                instr_out <= pend_instr;
                nop_out   <= 1'b0;
            end else if (buf_clear) begin
                PC_out    <= 32'd0;
                PC_4_out  <= 32'd0;
                instr_out <= NOP_INSTR;
                nop_out   <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Randomised bench for fetch_stage: a variable-latency memory model, a program-order
// reference queue filled by the driver, and a monitor that checks every presented word.
module tb_fetch_stage;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, stall, redirect;
    logic [31:0] redirect_pc;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] PC_out, PC_4_out, instr_out;
    logic        nop_out;

    initial forever #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .PC_out(PC_out),
        .PC_4_out(PC_4_out), .instr_out(instr_out), .nop_out(nop_out)
    );

    // Memory contents are a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    logic [31:0] exp_q[$];
    logic [31:0] tail;
    int          lat_min = 0, lat_max = 0;
    bit          expect_full = 0, expect_gap2 = 0, done = 0;
    int          wait_timeouts = 0;
    int          compared = 0, mismatched = 0, delivered = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one cycle; expected stream restarts after a reset or redirect cycle.
    task automatic step();
        @(posedge clk);
        #1;
        if (rst || redirect) begin
            exp_q.delete();
            tail = rst ? RST_PC : redirect_pc;
            exp_q.push_back(tail);
        end
        while (exp_q.size() < 8) begin
            tail = tail + 32'd4;
            exp_q.push_back(tail);
        end
    endtask

    initial begin : memory_model
        int cnt;
        bit busy;
        imem_ack = 1'b0; imem_rdata = 32'd0; busy = 0; cnt = 0;
        forever begin
            @(posedge clk);
            #2;
            if (imem_req !== 1'b1) begin
                busy = 0;
                imem_ack = 1'b0;
            end else begin
                if (!busy) begin
                    busy = 1;
                    cnt = $urandom_range(lat_max, lat_min);
                end
                if (cnt == 0) begin
                    imem_ack = 1'b1;
                    busy = 0;
                end else begin
                    imem_ack = 1'b0;
                    cnt--;
                end
            end
            imem_rdata = imem_ack ? mem_word(imem_addr) : $urandom;
        end
    end

    initial begin : driver
        bit found;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        lat_min = 0; lat_max = 0;
        repeat (3) step();
        rst = 1'b0;
        // Zero-wait memory: one instruction per cycle from the second cycle on.
        repeat (2) step();
        expect_full = 1;
        repeat (40) step();
        expect_full = 0;
        // Fixed two-cycle latency: exactly two bubbles between instructions.
        lat_min = 2; lat_max = 2;
        repeat (6) step();
        expect_gap2 = 1;
        repeat (40) step();
        expect_gap2 = 0;
        // Stall bursts long enough for the next word to be parked.
        lat_min = 1; lat_max = 1;
        for (int k = 0; k < 10; k++) begin
            stall = 1'b1; repeat (3) step();
            stall = 1'b0; repeat (3) step();
        end
        // Redirect while a request is still outstanding.
        lat_min = 3; lat_max = 3;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            step(); #2;
            found = imem_req && !imem_ack;
        end
        if (!found) wait_timeouts++;
        redirect = 1'b1; redirect_pc = 32'h0000_0100;
        step();
        redirect = 1'b0;
        repeat (15) step();
        // Redirect coinciding with an ack, together with a stall.
        lat_min = 0; lat_max = 0;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            step(); #2;
            found = imem_req && imem_ack;
        end
        if (!found) wait_timeouts++;
        redirect = 1'b1; redirect_pc = 32'h0000_0040; stall = 1'b1;
        step();
        redirect = 1'b0; stall = 1'b0;
        repeat (15) step();
        // Randomised traffic.
        lat_min = 0; lat_max = 3;
        for (int i = 0; i < 1500; i++) begin
            step();
            rst = ($urandom_range(199, 0) == 0);
            stall = ($urandom_range(9, 0) < 3);
            redirect = !rst && ($urandom_range(24, 0) == 0);
            case ($urandom_range(3, 0))
                0: redirect_pc = 32'hFFFF_FFF0 + {28'd0, 4'($urandom_range(15, 0))};
                1: redirect_pc = $urandom & 32'h0000_0FFC;
                default: redirect_pc = $urandom;
            endcase
        end
        rst = 1'b0; stall = 1'b0; redirect = 1'b0;
        repeat (5) step();
        // Reset while a word is parked.
        lat_min = 0; lat_max = 0;
        stall = 1'b1;
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            step();
            found = !imem_req && !nop_out;
        end
        if (!found) wait_timeouts++;
        rst = 1'b1;
        step();
        rst = 1'b0; stall = 1'b0;
        repeat (20) step();
        done = 1;
        step();
    end

    initial begin : monitor
        bit          armed = 0, rst_prev = 0, redir_prev = 0, req_prev = 0, ack_prev = 0;
        logic [31:0] addr_prev = 32'd0;
        int          cyc = 0, last_valid = -1;
        while (!done) begin
            @(negedge clk);
            cyc++;
            if (rst_prev) begin
                armed = 1;
                check("rst_req", {31'd0, imem_req}, 32'd0);
                check("rst_addr", imem_addr, 32'd0);
                check("rst_pc", PC_out, 32'd0);
                check("rst_pc4", PC_4_out, 32'd0);
                check("rst_instr", instr_out, NOP);
                check("rst_nop", {31'd0, nop_out}, 32'd1);
            end else if (armed) begin
                if (redir_prev) check("flush_after_redirect", {31'd0, nop_out}, 32'd1);
                if (req_prev && !ack_prev) begin
                    check("req_held", {31'd0, imem_req}, 32'd1);
                    check("addr_stable", imem_addr, addr_prev);
                end
                if (nop_out) begin
                    check("bubble_instr", instr_out, NOP);
                    check("bubble_pc", PC_out, 32'd0);
                    check("bubble_pc4", PC_4_out, 32'd0);
                end else if (exp_q.size() == 0) begin
                    compared++; mismatched++;
                    $display("FAIL unexpected_word: got pc %h expected none", PC_out);
                end else begin
                    check("pc_order", PC_out, exp_q[0]);
                    check("pc_plus4", PC_4_out, exp_q[0] + 32'd4);
                    check("instr_data", instr_out, mem_word(exp_q[0]));
                    if (!stall) begin
                        void'(exp_q.pop_front());
                        delivered++;
                    end
                end
                if (expect_full) check("full_rate", {31'd0, nop_out}, 32'd0);
                if (!expect_gap2) last_valid = -1;
                else if (!nop_out) begin
                    if (last_valid >= 0) check("gap_two_bubbles", cyc - last_valid - 1, 32'd2);
                    last_valid = cyc;
                end
            end
            rst_prev   = rst;
            redir_prev = redirect && !rst;
            req_prev   = imem_req;
            ack_prev   = imem_ack;
            addr_prev  = imem_addr;
        end
        check("deliveries_min", (delivered >= 200) ? 32'd1 : 32'd0, 32'd1);
        check("wait_timeouts", wait_timeouts, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage; sits directly upstream of the IF/ID pipeline register.
- Owns the program counter and issues word requests to instruction memory over a req/ack handshake with variable latency.
- Holds one fetched instruction in an output buffer that IF/ID samples. Honours hazard stalls and branch/jump redirects.
- Feeds IF/ID with PC, PC+4, instruction and a bubble flag; IF/ID treats the bubble flag as its nop input.

Parameters:
- RESET_PC, 32'h00000000, address of the first fetch after reset.
- NOP_INSTR, 32'h00000013, encoding driven on instr_out whenever the buffer is empty (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; synchronous and active-high.
- stall  in  1  hazard unit holds IF/ID; the buffered instruction must not be consumed.
- redirect  in  1  taken branch/jump from EX; flush and refetch.
- redirect_pc  in  32  target address; valid when redirect=1.
- imem_req  out  1  instruction-memory request.
- imem_addr  out  32  word address of the request; stable while imem_req=1 and no ack.
- imem_ack  in  1  rdata valid; only meaningful while imem_req=1.
- imem_rdata  in  32  instruction word.
- PC_out  out  32  PC of the buffered instruction.
- PC_4_out  out  32  PC_out+4, modulo 2^32.
- instr_out  out  32  buffered instruction.
- nop_out  out  1  1 = buffer empty (bubble); drives IF/ID nop.

Behaviour:
- Reset values: pc_q=RESET_PC; state=IDLE; imem_req=0; imem_addr=0; PC_out=0; PC_4_out=0; instr_out=NOP_INSTR; nop_out=1; pending buffer cleared.
- Reset mid-request: any outstanding request is abandoned; memory must tolerate req dropping.
- Consume condition: buffer is consumed on a cycle where nop_out=0 and stall=0.
- Buffer empty: nop_out=1, instr_out=NOP_INSTR, PC_out=PC_4_out=0.
- FSM states: IDLE, REQ, HOLD, DROP.
- IDLE: one cycle after rst deasserts. Next: REQ, with imem_req=1 and imem_addr=pc_q registered.
- REQ, ack present, and (buffer empty or consumed this cycle):
  - Load buffer with PC_out=imem_addr, PC_4_out=imem_addr+4, instr_out=imem_rdata, nop_out=0.
  - pc_q and imem_addr advance by 4; stay REQ with req held high.
  - Zero-wait memory (ack in the same cycle as req) therefore yields 1 instruction/cycle.
- REQ, ack present, buffer full and stall=1: capture rdata and address into the pending register; pc_q+=4; imem_req=0; go HOLD.
- REQ, no ack: if the buffer is consumed, the buffer empties (bubble). imem_addr stays stable.
- HOLD: imem_req=0. On a consume cycle, pending moves into the buffer (nop_out=0), then go REQ with imem_addr=pc_q.
- Redirect: highest priority over stall and ack in every state.
  - Buffer flushed to empty, pending discarded, pc_q<=redirect_pc.
  - From REQ with no ack this cycle: go DROP.
  - From REQ with ack this cycle: rdata discarded; go REQ with imem_addr=redirect_pc.
  - From HOLD or IDLE: go REQ with imem_addr=redirect_pc.
  - From DROP: stay DROP; pc_q is updated.
- DROP: imem_req=1 with the old address held. On ack, rdata is discarded and the state goes REQ with imem_addr=pc_q. The buffer stays empty throughout.
- Never more than one outstanding request. An instruction is never delivered twice or skipped.
- pc_q wraps modulo 2^32; no alignment check (redirect_pc[1:0] is passed through).

Decomposition:
- Shared package rv_core_pkg: NOP_INSTR constant, RESET_PC default, fetch_state_t enum (IDLE, REQ, HOLD, DROP).
- Single module; no sub-module. Buffer and pending register are inline.

Test Plan:
- Zero-wait memory, ack every req cycle, no stall, RESET_PC=0 → PC_out 0,4,8,12 on consecutive cycles from cycle 2 after rst release; nop_out=0 throughout.
- Memory latency 2 cycles → each instruction is followed by two bubbles (nop_out=1, instr_out=0x13); imem_addr stays stable until ack.
- Instr at 0x8 buffered, stall=1 for 3 cycles, ack for 0xC arrives → HOLD with req=0. PC_out stays 0x8 during the stall; 0x8 is consumed on the first non-stall cycle, then 0xC is presented next with no duplicate or skip.
- Request to 0x10 outstanding, redirect to 0x100, ack 2 cycles later → DROP; 0x10 data discarded. Next req addr=0x100; first delivered PC_out=0x100.
- Redirect to 0x40 and ack in the same cycle → data dropped, buffer flushed, next imem_addr=0x40; redirect+stall together also flushes.
- Assert rst while in HOLD → next cycle all outputs at reset values; refetch starts at RESET_PC.
